// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module      : regfile_2r1w
// Description : Two-read/one-write register file with registered reads and a
//               hardware clear engine. Optional macro REGFILE_BYPASS_EN turns
//               same-cycle read-after-write into write-first forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  input  logic              clr,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;
  logic                rvalid_a_q, rvalid_b_q;
  logic                addr_err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_idle;
  logic                w_access;
  logic                w_wr_ok, w_ra_ok, w_rb_ok;
  logic                w_wr_user;
  logic                w_rd_a_en, w_rd_b_en;
  logic                w_err;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_rd_a_data, w_rd_b_data;

  // ---------------------------------------------------------------------------
  // Access qualification
  // ---------------------------------------------------------------------------
  assign w_idle    = (state_q == S_IDLE);
  assign w_access  = w_idle & ~cs_n;
  assign w_wr_ok   = ({1'b0, waddr}   < c_depth);
  assign w_ra_ok   = ({1'b0, raddr_a} < c_depth);
  assign w_rb_ok   = ({1'b0, raddr_b} < c_depth);
  assign w_wr_user = w_access & we   & w_wr_ok;
  assign w_rd_a_en = w_access & re_a & w_ra_ok;
  assign w_rd_b_en = w_access & re_b & w_rb_ok;
  assign w_err     = w_access & ((we   & ~w_wr_ok) |
                                 (re_a & ~w_ra_ok) |
                                 (re_b & ~w_rb_ok));

  // ---------------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single array write port shared by the clear engine and the user
  // ---------------------------------------------------------------------------
  // rst_n gates the enable so the array keeps its contents while held in reset.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = waddr;
    w_mem_wdata = wdata;
    if (rst_n) begin
      if (!w_idle) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = cnt_q;
        w_mem_wdata = '0;
      end else if (w_wr_user) begin
        w_mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_mem_addr] <= w_mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_a_data = mem_q[raddr_a];
    w_rd_b_data = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_user && (waddr == raddr_a)) begin
      w_rd_a_data = wdata;
    end
    if (w_wr_user && (waddr == raddr_b)) begin
      w_rd_b_data = wdata;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rvalid_a_q <= w_rd_a_en;
      rvalid_b_q <= w_rd_b_en;
      addr_err_q <= w_err;
      if (w_rd_a_en) begin
        rdata_a_q <= w_rd_a_data;
      end
      if (w_rd_b_en) begin
        rdata_b_q <= w_rd_b_data;
      end
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign addr_err = addr_err_q;
  assign busy     = ~w_idle;

endmodule

`default_nettype wire
